// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Bus-slave word memory answering cpu32e2 read/write commands. Each command
//   is stalled for WAIT_STATES cycles via waitRequest. Writes are byte-masked
//   into the internal array. Reads return in order after READ_LATENCY cycles,
//   marked by a one-cycle readValid pulse. Read back-pressure is applied once
//   MAX_PENDING reads are in flight.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-low reset (memory array is not reset)
//   read / write     command request; both high is treated as a write
//   address          word address
//   byteWriteEnable  per-byte write lanes, bit n -> data[8n+7:8n]
//   writeData        write data
//   waitRequest      command stall (combinational)
//   readValid        one-cycle pulse qualifying readData
//   readData         read return data, held between pulses
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_PENDING  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [3:0]            byteWriteEnable,
    input  logic [31:0]           writeData,
    output logic                  waitRequest,
    output logic                  readValid,
    output logic [31:0]           readData
);

    localparam logic [2:0]  WAIT_LIMIT = 3'(WAIT_STATES);
    localparam logic [3:0]  PEND_LIMIT = 4'(MAX_PENDING);
    localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

    logic [31:0]             r_mem [DEPTH];
    logic [2:0]              r_wait_cnt;
    logic [READ_LATENCY-1:0] r_vld_p;
    logic [31:0]             r_rdata;

    logic        w_req;
    logic        w_is_read;
    logic        w_bp;
    logic        w_accept;
    logic        w_acc_rd;
    logic        w_acc_wr;
    logic [3:0]  w_pending;
    logic [31:0] w_rd_word;
    logic        w_last_vld;
    logic [31:0] w_last_dat;

    // Reads in flight: valid bits in every stage except the output stage.
    // The output-stage read retires on the coming edge, so a read accepted on
    // that same edge does not raise the count; this keeps one read per cycle
    // possible whenever MAX_PENDING >= READ_LATENCY.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
            w_pending = w_pending + 4'(r_vld_p[i]);
        end
    end

    assign w_req     = read | write;
    assign w_is_read = read & ~write;          // read+write is a write only
    assign w_bp      = w_is_read & (w_pending >= PEND_LIMIT);

    // Gated by reset so the stall output is 0 while reset is asserted.
    assign waitRequest = reset & w_req & ((r_wait_cnt != WAIT_LIMIT) | w_bp);
    assign w_accept    = reset & w_req & ~waitRequest;
    assign w_acc_wr    = w_accept & write;
    assign w_acc_rd    = w_accept & w_is_read;

    // Asynchronous array read: a write accepted on edge k is seen by a read
    // accepted on edge k+1.
    assign w_rd_word = r_mem[address];

    always_ff @(posedge clk) begin
        if (w_acc_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (byteWriteEnable[b]) begin
                    r_mem[address][8*b +: 8] <= writeData[8*b +: 8];
                end
            end
        end
    end

    // Data feeding the output register: straight from the array for a
    // single-stage pipeline, otherwise from the stage before the output.
    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign w_last_vld = w_acc_rd;
            assign w_last_dat = w_rd_word;
        end else begin : g_latn
            logic [31:0] r_dat_p [READ_LATENCY-1];

            // Intermediate data stages carry no reset; their valid bits do.
            always_ff @(posedge clk) begin
                r_dat_p[0] <= w_rd_word;
                for (int i = 1; i < int'(READ_LATENCY) - 1; i++) begin
                    r_dat_p[i] <= r_dat_p[i-1];
                end
            end

            assign w_last_vld = r_vld_p[READ_LATENCY-2];
            assign w_last_dat = r_dat_p[READ_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
            r_vld_p    <= '0;
            r_rdata    <= '0;
        end else begin
            // Dropped request or acceptance restarts the count; under
            // back-pressure the count parks at WAIT_STATES.
            if (!w_req || w_accept) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_LIMIT) begin
                r_wait_cnt <= r_wait_cnt + 3'd1;
            end

            r_vld_p[0] <= w_acc_rd;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
            end

            // Output data only moves with a valid read, so it holds between
            // readValid pulses.
            if (w_last_vld) begin
                r_rdata <= w_last_dat;
            end
        end
    end

    assign readValid = r_vld_p[READ_LATENCY-1];
    assign readData  = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Three responders with different configurations share clock and reset:
//     u0: WAIT_STATES=0, READ_LATENCY=1, MAX_PENDING=8
//     u1: WAIT_STATES=3, READ_LATENCY=1, MAX_PENDING=8
//     u2: WAIT_STATES=0, READ_LATENCY=4, MAX_PENDING=2
//   Reads push the expected word and the expected readValid cycle into a
//   per-instance queue; a negedge monitor pops and compares each pulse.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int NI = 3;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd   [NI];
    logic        wr   [NI];
    logic [9:0]  addr [NI];
    logic [3:0]  bwe  [NI];
    logic [31:0] wdat [NI];
    logic        wreq [NI];
    logic        rvld [NI];
    logic [31:0] rdat [NI];

    int          lat [NI] = '{1, 1, 4};
    logic [31:0] mdl [NI][1024];
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .READ_LATENCY(1), .MAX_PENDING(8)) u0 (
        .clk(clk), .reset(rst_n), .read(rd[0]), .write(wr[0]), .address(addr[0]),
        .byteWriteEnable(bwe[0]), .writeData(wdat[0]), .waitRequest(wreq[0]),
        .readValid(rvld[0]), .readData(rdat[0]));

    mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3), .READ_LATENCY(1), .MAX_PENDING(8)) u1 (
        .clk(clk), .reset(rst_n), .read(rd[1]), .write(wr[1]), .address(addr[1]),
        .byteWriteEnable(bwe[1]), .writeData(wdat[1]), .waitRequest(wreq[1]),
        .readValid(rvld[1]), .readData(rdat[1]));

    mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .READ_LATENCY(4), .MAX_PENDING(2)) u2 (
        .clk(clk), .reset(rst_n), .read(rd[2]), .write(wr[2]), .address(addr[2]),
        .byteWriteEnable(bwe[2]), .writeData(wdat[2]), .waitRequest(wreq[2]),
        .readValid(rvld[2]), .readData(rdat[2]));

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(input int k, input logic [31:0] d, input int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int k, output exp_t e);
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // Scoreboard monitor: every readValid pulse must match the oldest
    // outstanding read in both data and arrival cycle.
    task automatic mon_check(input int k);
        exp_t e;
        total++;
        if (qsize(k) == 0) begin
            bad++;
            $display("FAIL unexpected_readValid u%0d cyc=%0d: got readValid=1 data=%h, required readValid=0",
                     k, cyc, rdat[k]);
        end else begin
            pop_exp(k, e);
            if (rdat[k] !== e.data) begin
                bad++;
                $display("FAIL readData u%0d cyc=%0d: got %h, required %h", k, cyc, rdat[k], e.data);
            end
            total++;
            if (cyc !== e.due) begin
                bad++;
                $display("FAIL readValid_cycle u%0d: got cycle %0d, required %0d", k, cyc, e.due);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rvld[k] === 1'b1) mon_check(k);
        end
    end

    task automatic idle(input int k);
        rd[k]   = 1'b0;
        wr[k]   = 1'b0;
        addr[k] = '0;
        bwe[k]  = '0;
        wdat[k] = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until accepted; returns the number of
    // cycles waitRequest was high. Leaves the command asserted after the
    // accepting edge so back-to-back commands can follow directly.
    task automatic issue(input int k, input bit r, input bit w, input logic [9:0] a,
                         input logic [3:0] be, input logic [31:0] d, output int waits);
        rd[k]   = r;
        wr[k]   = w;
        addr[k] = a;
        bwe[k]  = be;
        wdat[k] = d;
        waits   = 0;
        #1;
        while (wreq[k] === 1'b1 && waits < 40) begin
            waits++;
            @(posedge clk);
            #1;
        end
        if (wreq[k] !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout u%0d addr=%0d: waitRequest=%b after %0d cycles, required 0",
                     k, a, wreq[k], waits);
            idle(k);
        end else begin
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[k][a][8*b +: 8] = d[8*b +: 8];
            end else if (r) begin
                push_exp(k, mdl[k][a], cyc + lat[k]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) idle(k);
        rd[1]   = 1'b1;              // a held command must not be accepted
        wr[0]   = 1'b1;
        bwe[0]  = 4'hF;
        addr[0] = 10'd9;
        wdat[0] = 32'h55AA55AA;
        rd[2]   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                total++;
                if (wreq[k] !== 1'b0 || rvld[k] !== 1'b0 || rdat[k] !== 32'h0) begin
                    bad++;
                    $display("FAIL reset_outputs u%0d cyc=%0d: got wreq=%b rvld=%b rdata=%h, required 0/0/0",
                             k, c, wreq[k], rvld[k], rdat[k]);
                end
            end
        end
        for (int k = 0; k < NI; k++) idle(k);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(2);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (wreq[k] !== 1'b0 || rvld[k] !== 1'b0 || rdat[k] !== 32'h0) begin
                bad++;
                $display("FAIL post_reset_idle u%0d: got wreq=%b rvld=%b rdata=%h, required 0/0/0",
                         k, wreq[k], rvld[k], rdat[k]);
            end
        end
        cycles(1);
    endtask

    task automatic test_byte_write();
        int w;
        issue(0, 0, 1, 10'd5, 4'b1111, 32'hDEADBEEF, w);
        total++;
        if (w !== 0) begin bad++; $display("FAIL bw_write_waits: got %0d, required 0", w); end
        issue(0, 0, 1, 10'd5, 4'b0001, 32'h000000AA, w);
        issue(0, 1, 0, 10'd5, 4'b0000, 32'h0, w);
        idle(0);
        total++;
        if (mdl[0][5] !== 32'hDEADBEAA) begin
            bad++;
            $display("FAIL bw_model: got %h, required DEADBEAA", mdl[0][5]);
        end
        cycles(2);
        // An all-zero lane mask is accepted and changes nothing.
        issue(0, 0, 1, 10'd5, 4'b0000, 32'hFFFFFFFF, w);
        total++;
        if (w !== 0) begin bad++; $display("FAIL bw_zero_mask_waits: got %0d, required 0", w); end
        issue(0, 1, 0, 10'd5, 4'b0000, 32'h0, w);
        issue(0, 0, 1, 10'd6, 4'b1010, 32'h11223344, w);
        issue(0, 0, 1, 10'd6, 4'b0101, 32'hA0B0C0D0, w);
        issue(0, 1, 0, 10'd6, 4'b0000, 32'h0, w);
        idle(0);
        cycles(3);
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 0; i < 6; i++)
            issue(0, 0, 1, 10'(100 + i), 4'hF, 32'h01010101 * (i + 3), w);
        for (int i = 0; i < 6; i++) begin
            issue(0, 1, 0, 10'(100 + i), 4'h0, 32'h0, w);
            total++;
            if (w !== 0) begin bad++; $display("FAIL b2b_read_waits i=%0d: got %0d, required 0", i, w); end
        end
        // Read-after-write on consecutive edges.
        issue(0, 0, 1, 10'd200, 4'hF, 32'hFEEDC0DE, w);
        issue(0, 1, 0, 10'd200, 4'h0, 32'h0, w);
        issue(0, 0, 1, 10'd200, 4'b1100, 32'h12340000, w);
        issue(0, 1, 0, 10'd200, 4'h0, 32'h0, w);
        idle(0);
        cycles(3);
    endtask

    task automatic test_wait_states();
        int w;
        issue(1, 0, 1, 10'd0, 4'hF, 32'hCAFEF00D, w);
        total++;
        if (w !== 3) begin bad++; $display("FAIL ws_write_waits: got %0d, required 3", w); end
        issue(1, 1, 0, 10'd0, 4'h0, 32'h0, w);
        total++;
        if (w !== 3) begin bad++; $display("FAIL ws_read_waits: got %0d, required 3", w); end
        issue(1, 1, 0, 10'd0, 4'h0, 32'h0, w);
        total++;
        if (w !== 3) begin bad++; $display("FAIL ws_read2_waits: got %0d, required 3", w); end
        idle(1);
        cycles(3);
    endtask

    task automatic test_backpressure();
        int w;
        issue(2, 0, 1, 10'd1, 4'hF, 32'h11111111, w);
        issue(2, 0, 1, 10'd2, 4'hF, 32'h22222222, w);
        issue(2, 0, 1, 10'd3, 4'hF, 32'h33333333, w);
        idle(2);
        cycles(2);
        issue(2, 1, 0, 10'd1, 4'h0, 32'h0, w);
        total++;
        if (w !== 0) begin bad++; $display("FAIL bp_read1_waits: got %0d, required 0", w); end
        issue(2, 1, 0, 10'd2, 4'h0, 32'h0, w);
        total++;
        if (w !== 0) begin bad++; $display("FAIL bp_read2_waits: got %0d, required 0", w); end
        // Two reads occupy the pipe until the first reaches the output stage.
        issue(2, 1, 0, 10'd3, 4'h0, 32'h0, w);
        total++;
        if (w !== 2) begin bad++; $display("FAIL bp_read3_waits: got %0d, required 2", w); end
        idle(2);
        cycles(8);
        // Writes pass while reads fill the pipeline.
        issue(2, 1, 0, 10'd1, 4'h0, 32'h0, w);
        issue(2, 1, 0, 10'd2, 4'h0, 32'h0, w);
        issue(2, 0, 1, 10'd4, 4'hF, 32'h44444444, w);
        total++;
        if (w !== 0) begin bad++; $display("FAIL bp_write_waits: got %0d, required 0", w); end
        issue(2, 1, 0, 10'd4, 4'h0, 32'h0, w);
        idle(2);
        cycles(8);
    endtask

    task automatic test_read_write_simul();
        int w;
        issue(0, 1, 1, 10'd7, 4'hF, 32'h12345678, w);
        total++;
        if (w !== 0) begin bad++; $display("FAIL rw_waits: got %0d, required 0", w); end
        idle(0);
        cycles(3);
        issue(0, 1, 0, 10'd7, 4'h0, 32'h0, w);
        idle(0);
        cycles(3);
    endtask

    task automatic test_reset_mid();
        int w;
        issue(2, 0, 1, 10'd30, 4'hF, 32'h30303030, w);
        issue(2, 0, 1, 10'd31, 4'hF, 32'h31313131, w);
        idle(2);
        cycles(5);
        issue(2, 1, 0, 10'd30, 4'h0, 32'h0, w);
        issue(2, 1, 0, 10'd31, 4'h0, 32'h0, w);
        idle(2);
        rst_n = 1'b0;
        q2.delete();           // in-flight reads are discarded
        @(negedge clk);
        total++;
        if (rvld[2] !== 1'b0 || rdat[2] !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got rvld=%b rdata=%h, required 0/0", rvld[2], rdat[2]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(8);
        issue(2, 1, 0, 10'd30, 4'h0, 32'h0, w);
        issue(2, 1, 0, 10'd31, 4'h0, 32'h0, w);
        idle(2);
        cycles(8);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) idle(k);
        test_reset();
        test_byte_write();
        test_back_to_back();
        test_wait_states();
        test_backpressure();
        test_read_write_simul();
        test_reset_mid();
        for (int c = 0; c < 20 && (q0.size() + q1.size() + q2.size()) != 0; c++) cycles(1);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (qsize(k) != 0) begin
                bad++;
                $display("FAIL outstanding_reads u%0d: got %0d never returned, required 0", k, qsize(k));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Bus-slave memory block that sits on the far side of the cpu32e2 data/instruction bus and answers its `read`/`write` commands. It drives `waitRequest` with a programmable number of wait states, performs byte-masked writes into an internal word array, and returns read data in order after a fixed pipeline latency with a one-cycle `readValid` pulse. It replaces the ad-hoc test RAM and stimulus muxing with one synthesizable responder for simulation and on-chip RAM use.

## Interface
- `ADDR_WIDTH`, 10, word-address width; the array holds 2**ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, 0, wait cycles inserted before each command is accepted (0..7).
- `READ_LATENCY`, 1, cycles from read acceptance to `readValid` (1..8).
- `MAX_PENDING`, 8, maximum reads in flight before back-pressure (1..8).
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `read`  in  1  read command request.
- `write`  in  1  write command request.
- `address`  in  ADDR_WIDTH  word address; bits [11:2] of the CPU `addressOut` when ADDR_WIDTH=10.
- `byteWriteEnable`  in  4  per-byte write lanes; bit n covers data bits [8n+7:8n].
- `writeData`  in  32  write data from the CPU `dataOut`.
- `waitRequest`  out  1  command stall; the command is held while this is 1.
- `readValid`  out  1  one-cycle pulse marking valid `readData`.
- `readData`  out  32  read return data to the CPU `dataIn`.

## Operation
- **Acceptance.** A command is accepted on a rising edge where (`read`|`write`) is 1 and `waitRequest` is 0. The master holds `address`, `writeData` and `byteWriteEnable` stable until then.
- **Wait counter.**
  - `waitCount` is 3 bits; reset value 0.
  - While a command is requested and `waitCount` != WAIT_STATES, `waitRequest`=1 and `waitCount` increments.
  - When `waitCount` == WAIT_STATES and the pipeline is not full, `waitRequest`=0 and the command is accepted. `waitCount` returns to 0 on acceptance.
  - If the request drops before acceptance (protocol violation), `waitCount` clears to 0 on the next edge.
- **Back-pressure.** `waitRequest`=1 whenever the reads in flight equal MAX_PENDING and the request is a read. Writes are never blocked by pending reads. `waitRequest` is combinational from `read`, `write`, `waitCount` and the pending count.
- **Writes.**
  - On acceptance, `mem[address]` lanes with `byteWriteEnable`=1 take `writeData`; other lanes are unchanged.
  - `byteWriteEnable`=0000 is accepted and changes nothing.
  - A write returns no `readValid`.
- **Reads.**
  - On acceptance, `mem[address]` is sampled into stage 0 of a READ_LATENCY-deep valid/data shift pipeline.
  - Results emerge strictly in acceptance order.
  - The pending count is the number of set valid bits in the pipeline, plus 1 for a read being accepted, minus 1 for one retiring in the same cycle.
- **Both `read` and `write` = 1** is treated as a write only; no `readValid` is produced.
- **Read-after-write** to the same word, accepted on consecutive cycles, returns the newly written data.
- **Reset.**
  - `reset` low clears `waitRequest` to 0, `readValid` to 0, `readData` to 0, `waitCount` to 0, and all pipeline valid bits.
  - In-flight reads are discarded. A reset mid-wait aborts the command.
  - Memory contents are not reset.

## Timing
- Acceptance occurs WAIT_STATES cycles after the request first appears, with `waitRequest` high for exactly WAIT_STATES cycles when no back-pressure applies.
- `readValid` rises READ_LATENCY edges after the accepting edge and stays high for one cycle per read.
- `readData` holds its last value while `readValid` is 0.
- Throughput is one command per (WAIT_STATES+1) cycles. With WAIT_STATES=0 and MAX_PENDING ≥ READ_LATENCY, throughput is one read per cycle.
- A write accepted at edge k is visible to a read accepted at edge k+1.

## Test plan
- **Reset.** Hold `reset` low 10 cycles, then release → `waitRequest`=0, `readValid`=0, `readData`=0 throughout; no command accepted.
- **Byte-masked write.** WAIT_STATES=0, READ_LATENCY=1:
  - write 0xDEADBEEF to address 5 with bwe=1111;
  - write 0x000000AA to address 5 with bwe=0001;
  - read address 5 → `readValid` one cycle after acceptance with `readData`=0xDEADBEAA.
- **Wait states.** WAIT_STATES=3: hold `read` on address 0 → `waitRequest` high exactly 3 cycles, accepted on the 4th edge, `readValid` READ_LATENCY cycles later.
- **Back-pressure.** READ_LATENCY=4, MAX_PENDING=2: issue back-to-back reads of addresses 1,2,3 → `waitRequest`=1 on the third read until the first retires; data returns in order 1,2,3, each with one `readValid` pulse.
- **Simultaneous read and write.** Assert `read`=`write`=1 at address 7 with writeData 0x12345678 → memory word 7 = 0x12345678, no `readValid` pulse.
- **Reset mid-operation.** Accept 2 reads with READ_LATENCY=4, then pulse `reset` low 1 cycle → no `readValid` is ever produced for those reads; memory contents are unchanged.
